// File: rtl/clk_div_if.sv
// clk_div_if: control and status bundle for the programmable clock divider
interface clk_div_if #(parameter int W = 8);
    logic         en;
    logic         div_load;
    logic [W-1:0] div_in;
    logic         clk_out;
    logic         tick;
    logic         running;
    logic [W-1:0] div_cur;
    logic         err;
    modport master (output en, div_load, div_in, input clk_out, tick, running, div_cur, err);
    modport slave  (input en, div_load, div_in, output clk_out, tick, running, div_cur, err);
endinterface

// File: rtl/clk_div_n.sv
// clk_div_n: glitch-free 50% duty integer divider with boundary-deferred divisor changes
module clk_div_n #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 3
) (
    input logic       clk,
    input logic       rst,
    clk_div_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t       state;
    logic [W-1:0] cnt, cur, pend, half;
    logic         p, n, pend_v, tick_q, err_q, legal, last;
    assign half  = cur >> 1;
    assign legal = bus.div_load && (bus.div_in >= W'(2));
    assign last  = cnt == cur - 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            p      <= 1'b0;
            tick_q <= 1'b0;
            cur    <= W'(DEFAULT_DIV);
            pend   <= '0;
            pend_v <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (bus.div_load && !legal) err_q <= 1'b1;
            if (state == IDLE) begin
                cnt    <= '0;
                p      <= bus.en;
                tick_q <= bus.en;
                state  <= bus.en ? RUN : IDLE;
                if (legal) cur <= bus.div_in;
            end else if (last) begin
                if (pend_v) begin
                    cur    <= pend;
                    pend_v <= 1'b0;
                end
                cnt    <= '0;
                p      <= bus.en;
                tick_q <= bus.en;
                state  <= bus.en ? RUN : IDLE;
            end else begin
                cnt    <= cnt + 1'b1;
                p      <= (cnt + 1'b1) < half;
                tick_q <= 1'b0;
            end
            // a load landing on the boundary edge must survive to the next boundary
            if (state == RUN && legal) begin
                pend   <= bus.div_in;
                pend_v <= 1'b1;
            end
        end
    end
    always_ff @(negedge clk) begin
        if (rst) n <= 1'b0;
        else     n <= p & cur[0];
    end
    assign bus.clk_out = p | n;
    assign bus.tick    = tick_q;
    assign bus.running = state == RUN;
    assign bus.div_cur = cur;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_clk_div_n.sv
// tb_clk_div_n: randomized and directed checks against a half-cycle waveform model
module tb_clk_div_n;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0;
    int fails = 0;
    clk_div_if #(.W(8)) bus ();
    clk_div_n #(.W(8), .DEFAULT_DIV(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    bit m_run, m_pv, m_err;
    int m_pos, m_cur = 3, m_pend;
    logic [12:0] obs, exp;

    // One clk cycle: drive, advance the model, sample after posedge and after negedge.
    // The model sees the output as high during the first N of the 2N half-cycles of a period.
    task automatic step(input bit r, input bit e, input bit ld, input int d);
        bit legal, was, hi_p, hi_n;
        rst = r;
        bus.en = e;
        bus.div_load = ld;
        bus.div_in = d[7:0];
        @(posedge clk);
        if (r) begin
            m_run = 0; m_pos = 0; m_cur = 3; m_pv = 0; m_err = 0;
        end else begin
            legal = ld && d >= 2;
            if (ld && !legal) m_err = 1;
            was = m_run;
            if (!m_run) begin
                if (legal) m_cur = d;
                if (e) begin m_run = 1; m_pos = 0; end
            end else if (m_pos == m_cur - 1) begin
                if (m_pv) begin m_cur = m_pend; m_pv = 0; end
                m_pos = 0;
                m_run = e;
            end else m_pos++;
            if (was && legal) begin m_pend = d; m_pv = 1; end
        end
        hi_p = m_run && (2 * m_pos < m_cur);
        hi_n = m_run && (2 * m_pos + 1 < m_cur);
        exp = {hi_p, hi_n, m_run && m_pos == 0, m_run, m_cur[7:0], m_err};
        #1;
        obs[12] = bus.clk_out & ~r;
        obs[10:0] = {bus.tick, bus.running, bus.div_cur, bus.err};
        @(negedge clk);
        #1;
        obs[11] = bus.clk_out;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0);
            if (obs !== 13'h0006) begin fails++; $display("FAIL reset cyc%0d got %h want %h", i, obs, 13'h0006); end
            tests++;
        end
    endtask

    task automatic test_default_odd;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0);
            if (obs !== exp) begin fails++; $display("FAIL default_odd cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
    endtask

    task automatic test_even_idle;
        for (int i = 0; i < 20; i++) begin
            step(0, i >= 6, i == 5, 4);
            if (obs !== exp) begin fails++; $display("FAIL even_idle cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
    endtask

    task automatic test_deferred;
        for (int i = 0; i < 30; i++) begin
            step(0, i >= 6, i == 5 || (i == 7), i == 5 ? 3 : 5);
            if (obs !== exp) begin fails++; $display("FAIL deferred cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
    endtask

    task automatic test_stop;
        bit e = 1;
        for (int i = 0; i < 40; i++) begin
            if (i > 12 && m_cur == 6 && m_pos == 1) e = 0;
            step(0, e, i == 0, 6);
            if (obs !== exp) begin fails++; $display("FAIL stop cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
        if (m_run) begin fails++; $display("FAIL stop_idle got running=1 want 0"); end
        tests++;
    endtask

    task automatic test_illegal;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, i == 3 || i == 7, i == 3 ? 1 : 0);
            if (obs !== exp) begin fails++; $display("FAIL illegal cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
    endtask

    task automatic test_reset_mid;
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            hit = m_run && m_cur == 7 && m_pos == 1;
            step(hit, !hit, i == 0, 7);
            if (obs !== exp) begin fails++; $display("FAIL reset_mid cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
        if (!hit) begin fails++; $display("FAIL reset_mid_reach got 0 want 1"); end
        tests++;
    endtask

    task automatic test_max;
        step(0, 0, 1, 255);
        for (int i = 0; i < 530; i++) begin
            step(0, i < 300, 0, 0);
            if (obs !== exp) begin fails++; $display("FAIL max cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9));
            if (obs !== exp) begin fails++; $display("FAIL random cyc%0d got %h want %h", i, obs, exp); end
            tests++;
        end
    endtask

    initial begin
        bus.en = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in = '0;
        test_reset;
        test_default_odd;
        test_even_idle;
        test_deferred;
        test_stop;
        test_illegal;
        test_reset_mid;
        test_max;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clk_div_n.md
# clk_div_n

Programmable integer clock divider. It generates `clk_out` with period N input clocks and an exact 50% duty cycle for both even and odd N. Odd divisors use a falling-edge half-cycle stretch flop. It supersedes the fixed divide-by-3 divider: the divisor is loaded at run time, and divisor changes and stop requests are applied only at period boundaries, so the output never glitches. `clk_out` feeds local clock-enable and slow-clock consumers; `tick` gives a clk-domain strobe for the same boundary.

## Interface
- `W`, 8: divisor width. Legal N is 2 .. 2^W-1.
- `DEFAULT_DIV`, 3: divisor after reset. Must be ≥2 and <2^W.
- `clk` in 1: input clock. All state is on posedge, except the odd-stretch flop, which is on negedge.
- `rst` in 1: synchronous, active-high reset, sampled on posedge `clk`. The negedge flop is also cleared at any negedge where `rst`=1.
- `en` in 1: run request.
- `div_load` in 1: single-cycle load strobe for `div_in`.
- `div_in` in W: requested divisor N.
- `clk_out` out 1: divided clock, equal to `p | n`.
- `tick` out 1: one-clk pulse in the first cycle of every `clk_out` period.
- `running` out 1: high when the state is not IDLE.
- `div_cur` out W: divisor currently in effect.
- `err` out 1: sticky flag, set when an illegal divisor load is rejected.

## Operation
- **Registers**
  - state ∈ {IDLE, RUN}
  - `cnt`[W-1:0]
  - `p` (posedge phase flop)
  - `n` (negedge stretch flop)
  - `div_cur`
  - `pend`[W-1:0], `pend_v`
  - `tick`, `err`
- **Half period:** H = floor(`div_cur`/2).
- **Phase flop:** `p` is registered and equals 1 exactly while in RUN with `cnt` < H.
- **Stretch flop:** `n` <= `p` & `div_cur`[0] on every negedge. It adds a half cycle of high time for odd N only.
- **Resulting waveform:** high for N/2 clk periods and low for N/2.
  - Even N: high 2, low 2 for N=4.
  - Odd N: high 1.5, low 1.5 for N=3; high 2.5, low 2.5 for N=5.
- **IDLE:**
  - `cnt`=0, `p`=0, `tick`=0.
  - At a posedge with `en`=1: go to RUN, `cnt`=0, `p`=1, `tick`=1.
- **RUN, `cnt` < `div_cur`-1:** `cnt`++ and `p` <= (`cnt`+1 < H); `tick`=0.
- **RUN, `cnt` == `div_cur`-1 (period boundary):**
  - If `pend_v`: `div_cur` <= `pend`, `pend_v` <= 0.
  - Then if `en`=1: `cnt`=0, `p`=1, `tick`=1. The new period uses the new divisor.
  - Else: go to IDLE with `p`=0. `en` low mid-period never truncates a period.
- **Loads:** a `div_load` with `div_in` ≥2 is legal.
  - In IDLE: `div_cur` <= `div_in` at the same posedge.
  - In RUN: `pend` <= `div_in`, `pend_v` <= 1. A later load before the boundary overwrites `pend`.
- **Illegal loads:** a load with `div_in` ∈ {0,1} is ignored, and `err` <= 1 until `rst`.
- **Same-edge load and boundary:** the load updates `pend` only. It takes effect at the next boundary, not the current one.

## Timing
- **Reset values:**
  - `clk_out`=0, `tick`=0, `running`=0, `err`=0.
  - `div_cur`=`DEFAULT_DIV`, `cnt`=0, `pend_v`=0, state IDLE.
- **Start latency:** `en` sampled high at posedge k gives `clk_out` and `tick` high from posedge k onward, with `running`=1.
- **`tick`:** asserted in every cycle where `cnt`==0 in RUN. Spacing is exactly `div_cur` clks.
- **Stop:** `running` and `p` fall at the boundary posedge following the deassertion of `en`. For odd N, `clk_out` has already returned low by that point.
- **Reset mid-run:** `p`=0 at the reset posedge. `clk_out` is low no later than the following negedge, and no partial high pulse is created afterwards.
- **Glitch freedom:** `clk_out` is an OR of two flops that never toggle on the same edge. It must not glitch.
- **Maximum divisor:** N = 2^W-1 (255 at W=8). `cnt` never exceeds N-1 and never wraps through 2^W.

## Test plan
- **Default odd divisor:** reset, then `en`=1 with `DEFAULT_DIV`=3 -> `clk_out` period 3 clk, high 1.5 clk; `tick` every 3rd cycle; `running`=1.
- **Even divisor from IDLE:** in IDLE load `div_in`=4, then `en`=1 -> high 2 clk, low 2 clk; `div_cur`=4.
- **Deferred load:** while running at N=3, load 5 at `cnt`=1 -> current period stays 3 clk; following periods are 5 clk, high 2.5; `div_cur` changes at the boundary.
- **Graceful stop:** at N=6, drop `en` at `cnt`=2 -> the period completes (high 3, low 3); at the boundary `clk_out`=0 and `running`=0; no `tick` afterwards.
- **Illegal loads:** `div_load` with `div_in`=1, then 0 -> `err`=1; `div_cur` unchanged; output period unaffected.
- **Reset during high phase and maximum N:** `rst` in the high phase at N=7 -> `clk_out` low by the next negedge and all reset values restored. Then N=255 -> period exactly 255 clk, high 127.5 clk.
